// File: rtl/tray_controller.sv
// tray_controller: runs the three-slot block tray (generate, fit scan, cursor, place handshake)
// and raises game_over when no free shape fits the board.
module tray_controller #(
    parameter int BLOCK_W     = 64,
    parameter int GEN_LATENCY = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    output logic               gen_new,
    input  logic [BLOCK_W-1:0] gen_block1,
    input  logic [BLOCK_W-1:0] gen_block2,
    input  logic [BLOCK_W-1:0] gen_block3,
    input  logic               sel_left,
    input  logic               sel_right,
    input  logic               sel_confirm,
    output logic [1:0]         cur_slot,
    output logic [BLOCK_W-1:0] cur_block,
    output logic [2:0]         used_mask,
    output logic               place_req,
    output logic [BLOCK_W-1:0] place_block,
    input  logic               place_ack,
    input  logic               place_nack,
    output logic               fit_req,
    output logic [BLOCK_W-1:0] fit_block,
    input  logic               fit_valid,
    input  logic               fit_ok,
    output logic               game_over,
    output logic               busy
);
    localparam int TW_A = $clog2(ACK_TIMEOUT + 1);
    localparam int TW_G = $clog2(GEN_LATENCY + 1);
    localparam int TW_M = (TW_A > TW_G) ? TW_A : TW_G;
    localparam int TW   = (TW_M > 8) ? TW_M : 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GEN    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_SELECT = 3'd5;
    localparam logic [2:0] S_PLACE  = 3'd6;
    localparam logic [2:0] S_OVER   = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [1:0]         cur_q, cur_d;
    logic [2:0]         used_q, used_d;
    logic [1:0]         chk_q, chk_d;
    logic               gap_q, gap_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [BLOCK_W-1:0] tray_q [3];
    logic [BLOCK_W-1:0] tray_d [3];
    logic [2:0]         above;
    logic [2:0]         placed;
    logic               tmo;

    function automatic logic [1:0] lowest_free(input logic [2:0] m);
        return !m[0] ? 2'd0 : (!m[1] ? 2'd1 : 2'd2);
    endfunction

    function automatic logic [1:0] step(input logic [1:0] s, input logic right);
        return right ? ((s == 2'd2) ? 2'd0 : s + 2'd1) : ((s == 2'd0) ? 2'd2 : s - 2'd1);
    endfunction

    // Nearest free slot in the given direction; stays put when no other slot is free.
    function automatic logic [1:0] next_free(input logic [1:0] s, input logic [2:0] m, input logic right);
        logic [1:0] a;
        logic [1:0] b;
        a = step(s, right);
        b = step(a, right);
        return !m[a] ? a : (!m[b] ? b : s);
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        used_d  = used_q;
        chk_d   = chk_q;
        gap_d   = 1'b0;
        tray_d  = tray_q;
        above   = ~used_q & (3'b110 << chk_q);
        placed  = used_q | (3'b001 << cur_q);
        tmo     = timer_q == TW'(ACK_TIMEOUT);
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_GEN;
                    used_d  = '0;
                end
            end
            S_GEN: state_d = S_WAIT;
            S_WAIT: begin
                if (int'(timer_q) + 1 >= GEN_LATENCY) state_d = S_LOAD;
            end
            S_LOAD: begin
                tray_d[0] = gen_block1;
                tray_d[1] = gen_block2;
                tray_d[2] = gen_block3;
                used_d    = '0;
                cur_d     = 2'd0;
                chk_d     = 2'd0;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                // gap_q is the idle cycle between two fit requests
                if (!gap_q) begin
                    if (fit_valid && fit_ok) begin
                        state_d = S_SELECT;
                        cur_d   = used_q[cur_q] ? lowest_free(used_q) : cur_q;
                    end else if (fit_valid || tmo) begin
                        if (above == 3'b000) begin
                            state_d = S_OVER;
                        end else begin
                            chk_d = lowest_free(~above);
                            gap_d = 1'b1;
                        end
                    end
                end
            end
            S_SELECT: begin
                if (sel_confirm) state_d = S_PLACE;
                else if (sel_left ^ sel_right) cur_d = next_free(cur_q, used_q, sel_right);
            end
            S_PLACE: begin
                if (place_ack) begin
                    used_d  = placed;
                    chk_d   = lowest_free(placed);
                    state_d = (&placed) ? S_GEN : S_CHECK;
                end else if (place_nack || tmo) begin
                    state_d = S_SELECT;
                end
            end
        endcase
        timer_d = (busy && state_d == state_q && !gap_d && !gap_q) ? timer_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cur_q   <= 2'd0;
            used_q  <= 3'b000;
            chk_q   <= 2'd0;
            gap_q   <= 1'b0;
            timer_q <= '0;
            tray_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            used_q  <= used_d;
            chk_q   <= chk_d;
            gap_q   <= gap_d;
            timer_q <= timer_d;
            tray_q  <= tray_d;
        end
    end

    assign gen_new     = state_q == S_GEN;
    assign fit_req     = (state_q == S_CHECK) && !gap_q;
    assign fit_block   = tray_q[chk_q];
    assign place_req   = state_q == S_PLACE;
    assign place_block = tray_q[cur_q];
    assign cur_slot    = cur_q;
    assign used_mask   = used_q;
    assign cur_block   = used_q[cur_q] ? '0 : tray_q[cur_q];
    assign game_over   = state_q == S_OVER;
    assign busy        = !(state_q == S_SELECT || state_q == S_IDLE || state_q == S_OVER);
endmodule
